// File: rtl/cpu2_core.sv
// cpu2_core: LED-matrix register machine with carry/zero flags, branches, button input and HALT.
// Defining CPU2_STACK_EN adds a STACK_DEPTH-entry return-address stack for CALL/RET.
module cpu2_core #(
   parameter int DATA_W      = 8,
   parameter int PC_W        = 11,
   parameter int ROM_LAT     = 1,
   parameter int STACK_DEPTH = 4,
   parameter int SCAN_LSB    = 13
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [7:0]      btn,
   input  logic [23:0]     counter,
   input  logic [15:0]     dout,
   output logic [PC_W-1:0] pc_out,
   output logic [3:0]      led,
   output logic [7:0]      row,
   output logic [7:0]      col,
   output logic            halted
);

   typedef enum logic [1:0] {
      S_FETCH,
      S_WAIT,
      S_EXEC,
      S_HALT
   } state_t;

   localparam logic [4:0] OP_MOV  = 5'b00001;
   localparam logic [4:0] OP_MVI  = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_XOR  = 5'b00111;
   localparam logic [4:0] OP_INC  = 5'b01000;
   localparam logic [4:0] OP_NOT  = 5'b01001;
   localparam logic [4:0] OP_ROR  = 5'b01010;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_IN   = 5'b01100;
   localparam logic [4:0] OP_JMP  = 5'b10000;
   localparam logic [4:0] OP_JC   = 5'b10001;
   localparam logic [4:0] OP_JNC  = 5'b10010;
   localparam logic [4:0] OP_JZ   = 5'b10011;
   localparam logic [4:0] OP_JNZ  = 5'b10100;
   localparam logic [4:0] OP_HALT = 5'b11111;

   // Last WAIT count before EXEC; unused when ROM_LAT=1 because WAIT is skipped.
   localparam logic [1:0] WAIT_LAST = 2'(ROM_LAT - 2);

   state_t            state_q, state_d;
   logic [1:0]        waitCnt_q, waitCnt_d;
   logic [PC_W-1:0]   pc_q, pc_d, pcInc, tgt;
   logic [DATA_W-1:0] regs_q [8];
   logic              c_q, c_d, z_q, z_d;
   logic [4:0]        op;
   logic [2:0]        rd, rs, scanIdx;
   logic [DATA_W-1:0] rdVal, rsVal, wrData;
   logic [DATA_W:0]   sum;
   logic              wrEn, updZ, stackErr;
   logic              unusedCounter;

`ifdef CPU2_STACK_EN
   localparam logic [4:0] OP_CALL = 5'b10101;
   localparam logic [4:0] OP_RET  = 5'b10110;
   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [PC_W-1:0] stack_q [STACK_DEPTH];
   logic [SP_W-1:0] sp_q, sp_d;
   logic            stackErr_q, stackErr_d, pushEn;
   logic [IDX_W-1:0] pushIdx, popIdx;

   assign pushIdx  = IDX_W'(sp_q);
   assign popIdx   = IDX_W'(sp_q - SP_W'(1));
   assign stackErr = stackErr_q;
`else
   localparam int unusedDepth = STACK_DEPTH;
   assign stackErr = 1'b0;
`endif

   assign op      = dout[15:11];
   assign rd      = dout[10:8];
   assign rs      = dout[7:5];
   assign tgt     = dout[PC_W-1:0];
   assign rdVal   = regs_q[rd];
   assign rsVal   = regs_q[rs];
   assign pcInc   = pc_q + PC_W'(1);
   assign scanIdx = counter[SCAN_LSB +: 3];
   assign unusedCounter = ^counter;

   assign pc_out = pc_q;
   assign halted = (state_q == S_HALT);
   assign led    = {halted, stackErr, z_q, c_q};

   // Matrix scan is purely combinational so the display keeps running while halted.
   always_comb begin
      row = '0;
      col = '1;
      for (int k = 0; k < 8; k++) begin
         row[7-k] = regs_q[scanIdx][k];
         col[7-k] = (scanIdx != 3'(k));
      end
   end

   always_comb begin
      state_d   = state_q;
      waitCnt_d = waitCnt_q;
      pc_d      = pc_q;
      c_d       = c_q;
      z_d       = z_q;
      wrEn      = 1'b0;
      wrData    = '0;
      updZ      = 1'b0;
      sum       = '0;
`ifdef CPU2_STACK_EN
      sp_d       = sp_q;
      stackErr_d = stackErr_q;
      pushEn     = 1'b0;
`endif
      case (state_q)
         S_FETCH: begin
            waitCnt_d = '0;
            state_d   = (ROM_LAT == 1) ? S_EXEC : S_WAIT;
         end
         S_WAIT: begin
            if (waitCnt_q == WAIT_LAST) state_d = S_EXEC;
            else waitCnt_d = waitCnt_q + 2'd1;
         end
         S_EXEC: begin
            state_d = S_FETCH;
            pc_d    = pcInc;
            case (op)
               OP_MOV: begin wrEn = 1'b1; wrData = rsVal; end
               OP_MVI: begin wrEn = 1'b1; wrData = DATA_W'(dout[7:0]); end
               OP_ADD: begin
                  sum    = {1'b0, rdVal} + {1'b0, rsVal};
                  wrEn   = 1'b1;
                  wrData = sum[DATA_W-1:0];
                  c_d    = sum[DATA_W];
                  updZ   = 1'b1;
               end
               OP_SUB: begin
                  wrEn   = 1'b1;
                  wrData = rdVal - rsVal;
                  c_d    = (rdVal < rsVal);
                  updZ   = 1'b1;
               end
               OP_AND: begin wrEn = 1'b1; wrData = rdVal & rsVal; c_d = 1'b0; updZ = 1'b1; end
               OP_OR:  begin wrEn = 1'b1; wrData = rdVal | rsVal; c_d = 1'b0; updZ = 1'b1; end
               OP_XOR: begin wrEn = 1'b1; wrData = rdVal ^ rsVal; c_d = 1'b0; updZ = 1'b1; end
               OP_INC: begin
                  sum    = {1'b0, rdVal} + (DATA_W+1)'(1);
                  wrEn   = 1'b1;
                  wrData = sum[DATA_W-1:0];
                  c_d    = sum[DATA_W];
                  updZ   = 1'b1;
               end
               OP_NOT: begin wrEn = 1'b1; wrData = ~rdVal; c_d = 1'b0; updZ = 1'b1; end
               OP_ROR: begin wrEn = 1'b1; wrData = {rdVal[0], rdVal[DATA_W-1:1]}; end
               OP_ROL: begin wrEn = 1'b1; wrData = {rdVal[DATA_W-2:0], rdVal[DATA_W-1]}; end
               OP_IN:  begin wrEn = 1'b1; wrData = DATA_W'(btn); end
               OP_JMP: pc_d = tgt;
               OP_JC:  if (c_q)  pc_d = tgt;
               OP_JNC: if (!c_q) pc_d = tgt;
               OP_JZ:  if (z_q)  pc_d = tgt;
               OP_JNZ: if (!z_q) pc_d = tgt;
`ifdef CPU2_STACK_EN
               // Overflowing CALL falls through to pc+1 and only raises the sticky error.
               OP_CALL: begin
                  if (sp_q == SP_W'(STACK_DEPTH)) begin
                     stackErr_d = 1'b1;
                  end else begin
                     pushEn = 1'b1;
                     sp_d   = sp_q + SP_W'(1);
                     pc_d   = tgt;
                  end
               end
               OP_RET: begin
                  if (sp_q == '0) begin
                     stackErr_d = 1'b1;
                  end else begin
                     sp_d = sp_q - SP_W'(1);
                     pc_d = stack_q[popIdx];
                  end
               end
`endif
               OP_HALT: begin
                  state_d = S_HALT;
                  pc_d    = pc_q;
               end
               default: ;
            endcase
            if (updZ) z_d = (wrData == '0);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         waitCnt_q <= '0;
         pc_q      <= '0;
         c_q       <= 1'b0;
         z_q       <= 1'b0;
         for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
         pc_q      <= pc_d;
         c_q       <= c_d;
         z_q       <= z_d;
         if (wrEn) regs_q[rd] <= wrData;
      end
   end

`ifdef CPU2_STACK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp_q       <= '0;
         stackErr_q <= 1'b0;
         for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
      end else begin
         sp_q       <= sp_d;
         stackErr_q <= stackErr_d;
         if (pushEn) stack_q[pushIdx] <= pcInc;
      end
   end
`endif

endmodule
